// File: rtl/setpoint_pkg.sv
// rtl/setpoint_pkg.sv - shared state encoding and board-default limits for the setpoint editor
package setpoint_pkg;

    localparam int unsigned SP_W = 12;
    localparam int unsigned TO_W = 28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EDIT_V = 2'b01,
        ST_EDIT_I = 2'b10
    } state_e;

    localparam logic [SP_W-1:0] DEF_V_MIN       = 12'd0;
    localparam logic [SP_W-1:0] DEF_V_MAX       = 12'd3000;
    localparam logic [SP_W-1:0] DEF_V_DEF       = 12'd500;
    localparam logic [SP_W-1:0] DEF_I_MIN       = 12'd0;
    localparam logic [SP_W-1:0] DEF_I_MAX       = 12'd2000;
    localparam logic [SP_W-1:0] DEF_I_DEF       = 12'd100;
    localparam logic [SP_W-1:0] DEF_STEP_FINE   = 12'd1;
    localparam logic [SP_W-1:0] DEF_STEP_COARSE = 12'd100;
    localparam logic [TO_W-1:0] DEF_TIMEOUT     = 28'd250_000_000;

endpackage

// File: rtl/setpoint_ctrl_sat_step.sv
// rtl/setpoint_ctrl_sat_step.sv - combinational saturating up/down step within [min,max]
module sat_step #(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] val_i,
    input  logic [W-1:0] step_i,
    input  logic [W-1:0] min_i,
    input  logic [W-1:0] max_i,
    input  logic         up_i,
    input  logic         dn_i,
    output logic [W-1:0] res_o
);

    logic [W:0] sum;
    logic [W:0] floor_thr;

    // One extra bit so neither val+step nor min+step can wrap before the compare.
    assign sum       = {1'b0, val_i} + {1'b0, step_i};
    assign floor_thr = {1'b0, min_i} + {1'b0, step_i};

    always_comb begin
        res_o = val_i;
        if (up_i && !dn_i) begin
            res_o = (sum > {1'b0, max_i}) ? max_i : sum[W-1:0];
        end else if (dn_i && !up_i) begin
            res_o = ({1'b0, val_i} < floor_thr) ? min_i : (val_i - step_i);
        end
    end

endmodule

// File: rtl/setpoint_ctrl.sv
// rtl/setpoint_ctrl.sv - key-driven voltage/current setpoint editor with timeout and commit strobe
module setpoint_ctrl
    import setpoint_pkg::*;
#(
    parameter int unsigned     W           = SP_W,
    parameter logic [W-1:0]    V_MIN       = DEF_V_MIN,
    parameter logic [W-1:0]    V_MAX       = DEF_V_MAX,
    parameter logic [W-1:0]    V_DEF       = DEF_V_DEF,
    parameter logic [W-1:0]    I_MIN       = DEF_I_MIN,
    parameter logic [W-1:0]    I_MAX       = DEF_I_MAX,
    parameter logic [W-1:0]    I_DEF       = DEF_I_DEF,
    parameter logic [W-1:0]    STEP_FINE   = DEF_STEP_FINE,
    parameter logic [W-1:0]    STEP_COARSE = DEF_STEP_COARSE,
    parameter logic [TO_W-1:0] TIMEOUT     = DEF_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_set,
    input  logic         key_up,
    input  logic         key_down,
    input  logic         key_step,
    output logic [W-1:0] v_set,
    output logic [W-1:0] i_set,
    output logic [W-1:0] disp_val,
    output logic [1:0]   edit_sel,
    output logic         step_coarse,
    output logic         apply
);

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - 28'd1;
    localparam logic [TO_W-1:0] TO_SAT  = {TO_W{1'b1}};

    state_e          state_q, state_d;
    logic [W-1:0]    v_set_q, v_set_d;
    logic [W-1:0]    i_set_q, i_set_d;
    logic [W-1:0]    v_sh_q, v_sh_d;
    logic [W-1:0]    i_sh_q, i_sh_d;
    logic [W-1:0]    disp_q, disp_d;
    logic            coarse_q, coarse_d;
    logic            apply_q, apply_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic [W-1:0] sat_val, sat_min, sat_max, sat_step_val, sat_res;
    logic         key_any;

    // Single stepper shared by both channels; the edit state picks its operand and bounds.
    assign sat_val      = (state_q == ST_EDIT_I) ? i_sh_q : v_sh_q;
    assign sat_min      = (state_q == ST_EDIT_I) ? I_MIN  : V_MIN;
    assign sat_max      = (state_q == ST_EDIT_I) ? I_MAX  : V_MAX;
    assign sat_step_val = coarse_q ? STEP_COARSE : STEP_FINE;
    assign key_any      = key_set | key_up | key_down | key_step;

    sat_step #(.W(W)) u_sat_step (
        .val_i  (sat_val),
        .step_i (sat_step_val),
        .min_i  (sat_min),
        .max_i  (sat_max),
        .up_i   (key_up),
        .dn_i   (key_down),
        .res_o  (sat_res)
    );

    always_comb begin
        state_d  = state_q;
        v_set_d  = v_set_q;
        i_set_d  = i_set_q;
        v_sh_d   = v_sh_q;
        i_sh_d   = i_sh_q;
        coarse_d = coarse_q;
        apply_d  = 1'b0;
        cnt_d    = cnt_q;
        disp_d   = disp_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (key_set) begin
                    state_d = ST_EDIT_V;
                    v_sh_d  = v_set_q;
                    i_sh_d  = i_set_q;
                end
            end
            ST_EDIT_V, ST_EDIT_I: begin
                if (key_set) begin
                    cnt_d = '0;
                    if (state_q == ST_EDIT_V) begin
                        state_d = ST_EDIT_I;
                    end else begin
                        state_d = ST_IDLE;
                        v_set_d = v_sh_q;
                        i_set_d = i_sh_q;
                        apply_d = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d  = ST_IDLE;
                    coarse_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    if (key_step) begin
                        coarse_d = ~coarse_q;
                    end
                    if (state_q == ST_EDIT_V) begin
                        v_sh_d = sat_res;
                    end else begin
                        i_sh_d = sat_res;
                    end
                    if (key_any) begin
                        cnt_d = '0;
                    end else if (cnt_q != TO_SAT) begin
                        cnt_d = cnt_q + 28'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Display follows the state being entered so it lines up with edit_sel.
        case (state_d)
            ST_EDIT_V: disp_d = v_sh_d;
            ST_EDIT_I: disp_d = i_sh_d;
            default:   disp_d = v_set_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            v_set_q  <= V_DEF;
            i_set_q  <= I_DEF;
            v_sh_q   <= V_DEF;
            i_sh_q   <= I_DEF;
            disp_q   <= V_DEF;
            coarse_q <= 1'b0;
            apply_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            v_set_q  <= v_set_d;
            i_set_q  <= i_set_d;
            v_sh_q   <= v_sh_d;
            i_sh_q   <= i_sh_d;
            disp_q   <= disp_d;
            coarse_q <= coarse_d;
            apply_q  <= apply_d;
            cnt_q    <= cnt_d;
        end
    end

    assign v_set       = v_set_q;
    assign i_set       = i_set_q;
    assign disp_val    = disp_q;
    assign edit_sel    = state_q;
    assign step_coarse = coarse_q;
    assign apply       = apply_q;

endmodule
